lift_display_ctrl: RTL and testbench
====================================

# lift_display_ctrl

Time-multiplexed scan controller for the lift's four-digit 7-segment display. It drives the 4-bit symbol code into the existing BCD-to-7-segment decoder and selects one digit anode per slot. The displayed content comes from the lift's floor, direction and alarm status: floor digit, animated direction arrow, and a blinking alarm screen. It sits between the lift control FSM and the decoder/anode pins.

## Interface
- REFRESH_DIV, default 50000: clk cycles per digit slot; legal values are 2 and above.
- ANIM_FRAMES, default 50: full 4-slot frames per arrow animation step; legal values are 1 and above.
- BLINK_FRAMES, default 100: frames per alarm blink half-period; legal values are 1 and above.
- clk  in  1  system clock; this is the block's only clock.
- rst  in  1  reset; synchronous and active-high.
- floor  in  3  current floor, 0..4.
- up  in  1  lift moving up.
- down  in  1  lift moving down.
- alarm  in  1  alarm active, level.
- code  out  4  symbol code to the decoder:
  - 0/1: down arrow frames
  - 2/3: up arrow frames
  - 4..8: floors 0..4
  - 9: alarm
  - 10: blank
- anode  out  4  digit select, active-low; bit n corresponds to slot n.

## Operation
- **Prescaler.** `pcnt` counts 0..REFRESH_DIV-1 and asserts `tick` when `pcnt` equals REFRESH_DIV-1. On `tick`:
  - `slot` advances 0→1→2→3→0.
  - The 3→0 wrap is a frame boundary, `frame`.
- **Mode FSM.** The FSM is evaluated every clk; its states are S_IDLE, S_UP, S_DOWN and S_ALARM.
  - `alarm`=1 goes to S_ALARM from any state. Alarm has the highest priority.
  - `alarm`=0 and `up`=1, `down`=0 goes to S_UP.
  - `alarm`=0 and `down`=1, `up`=0 goes to S_DOWN.
  - `alarm`=0 with `up`=`down` (both 0 or both 1) goes to S_IDLE.
- **Animation.** Phase bit `aph` and frame counter `acnt` advance as follows:
  - `acnt` counts frames; at ANIM_FRAMES-1 it wraps to 0 and `aph` toggles.
  - Any change of FSM state clears `acnt` and `aph` to 0 in the same cycle.
- **Blink.** Phase bit `bph` (1 means on) and frame counter `bcnt` advance as follows:
  - `bcnt` counts frames only in S_ALARM; at BLINK_FRAMES-1 it wraps to 0 and `bph` toggles.
  - Entry into S_ALARM sets `bph`=1 and `bcnt`=0.
- **Slot content** in S_IDLE, S_UP and S_DOWN:
  - slot 0 shows floor: code = 4+`floor`; a `floor` value above 4 gives code 10.
  - slot 1 shows direction:
    - S_UP: code 2 when `aph`=0, 3 when `aph`=1.
    - S_DOWN: code 0 when `aph`=0, 1 when `aph`=1.
    - S_IDLE: code 10.
  - slots 2 and 3: code 10 with the anode held inactive.
- **Slot content** in S_ALARM:
  - With `bph`=1, every slot shows code 9 with its anode active.
  - With `bph`=0, every slot shows code 10 with all anodes inactive.
- **Output register update.**
  - `code` and `anode` are registered and update only on `tick`.
  - The new values are computed for the new slot from the FSM state, `aph` and `bph` as they stand in the tick cycle, and the inputs sampled in that cycle.
  - When a `frame` tick and a phase toggle coincide, the new frame's slot 0 uses the pre-toggle phase values. The slot 1 decision is taken one tick later, so it uses the post-toggle value.

## Timing
- Values forced by `rst`:
  - `pcnt`=0 and `slot`=3.
  - FSM state S_IDLE.
  - `aph`=0, `acnt`=0, `bph`=1, `bcnt`=0.
  - `code`=10 and `anode`=4'b1111.
- Asserting `rst` mid-scan or mid-alarm behaves identically to reset at power-up; no partial frame is emitted afterwards.
- The first `tick` arrives REFRESH_DIV cycles after `rst` is released. At that tick `slot` becomes 0 and `anode` becomes 4'b1110.
- A change on an input becomes visible on `code` at the first `tick` in which the slot that depends on that input is selected. The latency is at most 4·REFRESH_DIV cycles.
- The FSM state responds one clk after an input change.
- `code` and `anode` always change in the same cycle. At most one bit of `anode` is 0 at any time.

## Configuration
- `LIFT_DISP_BLINK_EN` compiled in: alarm blinks as described in Operation, with a period of 2·BLINK_FRAMES frames.
- `LIFT_DISP_BLINK_EN` absent:
  - `bph` is held at 1 and the `bcnt` logic is removed.
  - Alarm shows code 9 on all four digits steadily.

## Structure
- A shared package `lift_pkg` holds:
  - The symbol code constants: SYM_DN0=0, SYM_DN1=1, SYM_UP0=2, SYM_UP1=3, SYM_FLOOR_BASE=4, SYM_ALARM=9, SYM_OFF=10.
  - The FSM state encoding.
  - MAX_FLOOR=4.
- One natural sub-module, `scan_tick`: the prescaler plus slot counter, emitting `tick`, `frame` and `slot`.
- The decoder itself stays outside this block; `code` connects to its 4-bit input.

## Test plan
All scenarios use REFRESH_DIV=4, ANIM_FRAMES=2 and BLINK_FRAMES=2.
1. Reset and idle:
   - Stimulus: `rst` then release, with `floor`=2 and no motion.
   - Required response: `anode`=1111 and `code`=10 for 4 cycles; then `anode`=1110 with `code`=6, then 1101 with `code`=10, then slots 2 and 3 with `anode`=1111.
2. Up animation:
   - Stimulus: `up`=1 held.
   - Required response: slot 1 shows code 2 for 2 frames, then 3 for 2 frames, repeating.
   - Stimulus: switch to `down`=1.
   - Required response: slot 1 restarts at code 0.
3. Invalid inputs:
   - Stimulus: `floor`=6.
   - Required response: slot 0 shows code 10.
   - Stimulus: `up`=`down`=1.
   - Required response: slot 1 shows code 10 (S_IDLE).
4. Alarm blink (macro on):
   - Stimulus: `alarm` pulsed high mid-frame and held.
   - Required response: from the next `tick`, all anodes in turn show code 9 for 2 frames, then `anode`=1111 for 2 frames, repeating.
   - Stimulus: `alarm` released.
   - Required response: normal content resumes at the next tick.
5. Alarm steady (macro off):
   - Stimulus: `alarm` held for 10 frames.
   - Required response: code 9 in every slot, with an active anode in every slot.
6. Reset mid-alarm:
   - Stimulus: `rst` asserted during the `bph`=0 phase.
   - Required response: next cycle `code`=10, `anode`=1111 and `bph`=1.

Source files
------------

// File: rtl/lift_pkg.sv
// Shared symbol codes, mode encoding and debug view for the lift display
// scan controller.
package lift_pkg;

  localparam logic [3:0] SYM_DN0        = 4'd0;
  localparam logic [3:0] SYM_DN1        = 4'd1;
  localparam logic [3:0] SYM_UP0        = 4'd2;
  localparam logic [3:0] SYM_UP1        = 4'd3;
  localparam logic [3:0] SYM_FLOOR_BASE = 4'd4;
  localparam logic [3:0] SYM_ALARM      = 4'd9;
  localparam logic [3:0] SYM_OFF        = 4'd10;

  localparam logic [2:0] MAX_FLOOR = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_UP    = 2'd1,
    S_DOWN  = 2'd2,
    S_ALARM = 2'd3
  } lift_state_e;

  typedef struct packed {
    lift_state_e state;
    logic        aph;
    logic        bph;
  } lift_dbg_t;

  // Out-of-range floors are blanked rather than shown as garbage symbols.
  function automatic logic [3:0] floor_sym(input logic [2:0] f);
    return (f > MAX_FLOOR) ? SYM_OFF : SYM_FLOOR_BASE + {1'b0, f};
  endfunction

endpackage

// File: rtl/lift_display_ctrl_scan_tick.sv
// Prescaler and digit slot counter: one tick per REFRESH_DIV clocks,
// frame flags the slot 3 -> 0 wrap.
module scan_tick #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic       o_tick,
  output logic       o_frame,
  output logic [1:0] o_slot
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [PW-1:0] r_pcnt;
  logic [1:0]    r_slot;
  logic          w_tick;

  assign w_tick  = (r_pcnt == PW'(REFRESH_DIV - 1));
  assign o_tick  = w_tick;
  assign o_frame = w_tick && (r_slot == 2'd3);
  assign o_slot  = r_slot;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pcnt <= '0;
      r_slot <= 2'd3;
    end else if (w_tick) begin
      r_pcnt <= '0;
      r_slot <= r_slot + 2'd1;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

endmodule

// File: rtl/lift_display_ctrl.sv
// Lift 4-digit display scan controller: floor, animated arrow, alarm screen.
// Alarm blinking is compiled in with LIFT_DISP_BLINK_EN; otherwise steady.
module lift_display_ctrl
  import lift_pkg::*;
#(
  parameter int REFRESH_DIV  = 50000,
  parameter int ANIM_FRAMES  = 50,
  parameter int BLINK_FRAMES = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] floor,
  input  logic       up,
  input  logic       down,
  input  logic       alarm,
  output logic [3:0] code,
  output logic [3:0] anode,
  output lift_dbg_t  o_dbg
);

  localparam int AW = (ANIM_FRAMES > 2) ? $clog2(ANIM_FRAMES) : 1;

  logic        w_tick, w_frame, w_bph, w_state_chg;
  logic [1:0]  w_slot, w_slot_nxt;
  logic [3:0]  w_sel, w_code_nxt, w_anode_nxt;
  lift_state_e r_state, w_state_nxt;
  logic        r_aph;
  logic [AW-1:0] r_acnt;
  logic [3:0]  r_code, r_anode;

  scan_tick #(.REFRESH_DIV(REFRESH_DIV)) u_scan_tick (
    .i_clk   (clk),
    .i_rst   (rst),
    .o_tick  (w_tick),
    .o_frame (w_frame),
    .o_slot  (w_slot)
  );

  always_comb begin
    w_state_nxt = S_IDLE;
    if (alarm)             w_state_nxt = S_ALARM;
    else if (up && !down)  w_state_nxt = S_UP;
    else if (down && !up)  w_state_nxt = S_DOWN;
  end

  assign w_state_chg = (w_state_nxt != r_state);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || w_state_chg) begin
      r_aph  <= 1'b0;
      r_acnt <= '0;
    end else if (w_frame) begin
      if (r_acnt == AW'(ANIM_FRAMES - 1)) begin
        r_acnt <= '0;
        r_aph  <= ~r_aph;
      end else begin
        r_acnt <= r_acnt + 1'b1;
      end
    end
  end

`ifdef LIFT_DISP_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;
  logic          r_bph;
  logic [BW-1:0] r_bcnt;

  // Every alarm episode starts in the visible half of the blink.
  always_ff @(posedge clk) begin
    if (rst || (w_state_nxt == S_ALARM && r_state != S_ALARM)) begin
      r_bph  <= 1'b1;
      r_bcnt <= '0;
    end else if (r_state == S_ALARM && w_frame) begin
      if (r_bcnt == BW'(BLINK_FRAMES - 1)) begin
        r_bcnt <= '0;
        r_bph  <= ~r_bph;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
      end
    end
  end
  assign w_bph = r_bph;
`else
  assign w_bph = 1'b1;
`endif

  // Content is computed for the slot the tick is about to select.
  assign w_slot_nxt = w_slot + 2'd1;
  assign w_sel      = ~(4'b0001 << w_slot_nxt);

  always_comb begin
    w_code_nxt  = SYM_OFF;
    w_anode_nxt = 4'b1111;
    if (r_state == S_ALARM) begin
      if (w_bph) begin
        w_code_nxt  = SYM_ALARM;
        w_anode_nxt = w_sel;
      end
    end else begin
      case (w_slot_nxt)
        2'd0: begin
          w_code_nxt  = floor_sym(floor);
          w_anode_nxt = w_sel;
        end
        2'd1: begin
          w_anode_nxt = w_sel;
          if (r_state == S_UP)        w_code_nxt = r_aph ? SYM_UP1 : SYM_UP0;
          else if (r_state == S_DOWN) w_code_nxt = r_aph ? SYM_DN1 : SYM_DN0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_code  <= SYM_OFF;
      r_anode <= 4'b1111;
    end else if (w_tick) begin
      r_code  <= w_code_nxt;
      r_anode <= w_anode_nxt;
    end
  end

  assign code        = r_code;
  assign anode       = r_anode;
  assign o_dbg.state = r_state;
  assign o_dbg.aph   = r_aph;
  assign o_dbg.bph   = w_bph;

endmodule

// File: tb/tb_lift_display_ctrl.sv
// Bench for lift_display_ctrl: cycle model feeds an expected queue on every
// scan tick; the checker pops on the following falling edge.
module tb_lift_display_ctrl;
  import lift_pkg::*;

  localparam int DIV = 4;
  localparam int AF  = 2;
  localparam int BF  = 2;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] floor = 3'd2;
  logic       up = 1'b0, down = 1'b0, alarm = 1'b0;
  logic [3:0] code, anode;
  lift_dbg_t  dbg;

  int n_vec = 0;
  int n_err = 0;

  lift_display_ctrl #(.REFRESH_DIV(DIV), .ANIM_FRAMES(AF), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .floor(floor), .up(up), .down(down), .alarm(alarm),
    .code(code), .anode(anode), .o_dbg(dbg)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model
  int          m_pcnt, m_slot, m_acnt, m_bcnt;
  bit          m_aph, m_bph;
  lift_state_e m_st;
  logic [7:0]  m_out;
  logic [7:0]  exp_q[$];
  bit          pending;

  function automatic logic [7:0] model_out(lift_state_e st, int slot, bit aph, bit bph,
                                           logic [2:0] fl);
    logic [3:0] c;
    logic [3:0] a;
    logic [3:0] on;
    c  = 4'd10;
    a  = 4'hF;
    on = 4'hF;
    on[slot] = 1'b0;
    if (st == S_ALARM) begin
      if (bph) begin
        c = 4'd9;
        a = on;
      end
    end else if (slot == 0) begin
      a = on;
      c = (fl <= 3'd4) ? 4'd4 + {1'b0, fl} : 4'd10;
    end else if (slot == 1) begin
      a = on;
      if (st == S_UP)        c = aph ? 4'd3 : 4'd2;
      else if (st == S_DOWN) c = aph ? 4'd1 : 4'd0;
    end
    return {c, a};
  endfunction

  initial begin
    lift_state_e nst;
    bit tk, fr;
    int ns;
    forever begin
      @(posedge clk);
      if (alarm)             nst = S_ALARM;
      else if (up && !down)  nst = S_UP;
      else if (down && !up)  nst = S_DOWN;
      else                   nst = S_IDLE;
      if (rst) begin
        m_pcnt = 0; m_slot = 3; m_st = S_IDLE;
        m_aph = 0; m_acnt = 0; m_bph = 1; m_bcnt = 0;
        m_out = {4'd10, 4'hF};
        exp_q.delete();
        pending = 0;
      end else begin
        tk = (m_pcnt == DIV - 1);
        fr = tk && (m_slot == 3);
        if (tk) begin
          ns = (m_slot + 1) % 4;
          m_out = model_out(m_st, ns, m_aph, m_bph, floor);
          exp_q.push_back(m_out);
          pending = 1;
        end
        if (nst != m_st) begin
          m_aph = 0; m_acnt = 0;
        end else if (fr) begin
          m_acnt++;
          if (m_acnt == AF) begin m_acnt = 0; m_aph = !m_aph; end
        end
`ifdef LIFT_DISP_BLINK_EN
        if (nst == S_ALARM && m_st != S_ALARM) begin
          m_bph = 1; m_bcnt = 0;
        end else if (m_st == S_ALARM && fr) begin
          m_bcnt++;
          if (m_bcnt == BF) begin m_bcnt = 0; m_bph = !m_bph; end
        end
`endif
        m_pcnt = tk ? 0 : m_pcnt + 1;
        if (tk) m_slot = (m_slot + 1) % 4;
        m_st = nst;
      end
    end
  end

  // scoreboard
  bit chk_en = 1'b0;
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        if (pending) begin
          pending = 0;
          if (exp_q.size() == 0) check("queue_empty", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            check("tick_out", {code, anode}, e);
          end
        end else begin
          check("hold_out", {code, anode}, m_out);
        end
        check("state", dbg.state, m_st);
        check("one_cold", ($countones(~anode) > 1) ? 32'd1 : 32'd0, 32'd0);
      end
    end
  end

  // driver tasks
  task automatic run(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic set_in(input logic [2:0] f, input logic u, input logic d, input logic a);
    floor = f; up = u; down = d; alarm = a;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(1);
    check("rst_code", code, 32'd10);
    check("rst_anode", anode, 32'hF);
    check("rst_bph", dbg.bph, 32'd1);
    check("rst_state", dbg.state, S_IDLE);
    run(1);
    rst = 1'b0;
  endtask

  initial begin
    int budget;
    run(1);
    do_reset();
    chk_en = 1'b1;
    // idle, floor 2: first tick lands DIV cycles after release
    set_in(3'd2, 0, 0, 0);
    run(DIV - 1);
    check("t1_pre_tick_code", code, 32'd10);
    check("t1_pre_tick_anode", anode, 32'hF);
    run(1);
    check("t1_slot0_code", code, 32'd6);
    check("t1_slot0_anode", anode, 32'hE);
    run(DIV);
    check("t1_slot1_code", code, 32'd10);
    check("t1_slot1_anode", anode, 32'hD);
    run(5 * FRAME);
    // up animation then down
    set_in(3'd1, 1, 0, 0);
    run(10 * FRAME);
    set_in(3'd3, 0, 1, 0);
    run(8 * FRAME);
    // invalid inputs
    set_in(3'd6, 0, 1, 0);
    run(2 * FRAME);
    set_in(3'd4, 1, 1, 0);
    run(2 * FRAME);
    // alarm raised mid-frame, held, released
    run(5);
    set_in(3'd0, 1, 0, 1);
    run(10 * FRAME);
    set_in(3'd0, 1, 0, 0);
    run(3 * FRAME);
    // reset during the dark half of the blink
    set_in(3'd3, 0, 0, 1);
`ifdef LIFT_DISP_BLINK_EN
    budget = 0;
    while (m_bph && budget < 20 * FRAME) begin run(1); budget++; end
    check("bph_low_reached", {31'd0, m_bph}, 32'd0);
`else
    budget = 0;
    run(4 * FRAME + 3);
`endif
    chk_en = 1'b0;
    do_reset();
    chk_en = 1'b1;
    set_in(3'd3, 0, 0, 0);
    run(3 * FRAME);
    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      set_in(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
      run($urandom_range(1, 3 * FRAME));
    end
    run(2 * FRAME);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
